// File: rtl/song_time_bcd_pkg.sv
// song_time_bcd_pkg: shared FSM states and conversion constants for the m:ss BCD converter
package song_time_bcd_pkg;
  typedef enum logic [1:0] {IDLE, MIN, TENS, LOAD} state_t;
  localparam logic [7:0] SECS_PER_MIN = 8'd60;
  localparam logic [7:0] TEN = 8'd10;
  localparam int BCD_W = 4;
endpackage

// File: rtl/song_time_bcd_blink_gen.sv
// blink_gen: half-period phase toggler that runs while enabled and restarts from a visible phase
module blink_gen #(
  parameter int HALF_PERIOD = 6750000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic phase
);
  logic [22:0] cnt;
  // count while enabled, wrap and toggle at the half-period, clear when idle
  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      cnt <= '0;
      phase <= 1'b0;
    end else if (cnt == 23'(HALF_PERIOD - 1)) begin
      cnt <= '0;
      phase <= ~phase;
    end else begin
      cnt <= cnt + 23'd1;
    end
  end
endmodule

// File: rtl/song_time_bcd.sv
// song_time_bcd: converts an 8-bit seconds count to m:ss BCD digits by repeated subtraction; PAUSE_BLINK_EN adds pause blinking
module song_time_bcd
  import song_time_bcd_pkg::*;
#(
  parameter int BLINK_HALF_PERIOD = 6750000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       seconds,
  input  logic             pause_song,
  output logic [BCD_W-1:0] minutes,
  output logic [BCD_W-1:0] sec_tens,
  output logic [BCD_W-1:0] sec_ones,
  output logic             update,
  output logic             blank
);
  state_t state, state_n;
  logic [7:0] rem, rem_n, last_seconds, last_n;
  logic [2:0] min_cnt, min_n, tens_cnt, tens_n;
  logic load;
  // next-state and datapath: capture on change, peel off minutes then tens, then load digits
  always_comb begin
    state_n = state;
    rem_n = rem;
    last_n = last_seconds;
    min_n = min_cnt;
    tens_n = tens_cnt;
    load = 1'b0;
    case (state)
      IDLE: if (seconds != last_seconds) begin
        rem_n = seconds;
        last_n = seconds;
        min_n = '0;
        tens_n = '0;
        state_n = MIN;
      end
      MIN: if (rem >= SECS_PER_MIN) begin
        rem_n = rem - SECS_PER_MIN;
        min_n = min_cnt + 3'd1;
      end else state_n = TENS;
      TENS: if (rem >= TEN) begin
        rem_n = rem - TEN;
        tens_n = tens_cnt + 3'd1;
      end else state_n = LOAD;
      LOAD: begin
        load = 1'b1;
        state_n = IDLE;
      end
    endcase
  end
  // state, working registers and held output digits
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      rem <= '0;
      last_seconds <= '0;
      min_cnt <= '0;
      tens_cnt <= '0;
      minutes <= '0;
      sec_tens <= '0;
      sec_ones <= '0;
      update <= 1'b0;
    end else begin
      state <= state_n;
      rem <= rem_n;
      last_seconds <= last_n;
      min_cnt <= min_n;
      tens_cnt <= tens_n;
      update <= load;
      if (load) begin
        minutes <= {1'b0, min_cnt};
        sec_tens <= {1'b0, tens_cnt};
        sec_ones <= rem[3:0];
      end
    end
  end
`ifdef PAUSE_BLINK_EN
  logic phase;
  blink_gen #(.HALF_PERIOD(BLINK_HALF_PERIOD)) u_blink (
    .clk(clk),
    .reset(reset),
    .enable(pause_song),
    .phase(phase)
  );
  assign blank = pause_song & phase;
`else
  localparam int unused_half = BLINK_HALF_PERIOD;
  logic unused_pause;
  assign unused_pause = pause_song;
  assign blank = 1'b0;
`endif
endmodule

// File: doc/song_time_bcd.md
Name: song_time_bcd

Overview:
- Downstream consumer of the song elapsed-time counter: takes the 8-bit `seconds` count (0–255) and converts it to m:ss BCD digits for the hex display and graphics overlay.
- Conversion is sequential, by repeated subtraction (no divider), and starts automatically whenever the input count changes.
- Digits are held stable between conversions; a one-cycle `update` strobe marks each new value.

Parameters:
- BLINK_HALF_PERIOD, 6750000, clock cycles per blink half-period (0.25 s at 27 MHz). Used only with PAUSE_BLINK_EN.

Ports:
- clk  in  1  system clock (27 MHz)
- reset  in  1  synchronous, active-high reset
- seconds  in  8  elapsed song seconds from the timing stage
- pause_song  in  1  pause flag from the central FSM (used only with PAUSE_BLINK_EN)
- minutes  out  4  BCD minutes, range 0–4
- sec_tens  out  4  BCD tens of seconds, range 0–5
- sec_ones  out  4  BCD ones of seconds, range 0–9
- update  out  1  one-cycle pulse when new digits are loaded
- blank  out  1  display blank request

Behaviour:
- Interface: one clock; reset is synchronous and active-high (ports `clk`, `reset`).
- Reset values:
  - minutes = sec_tens = sec_ones = 0, update = 0, blank = 0.
  - State = IDLE; last_seconds = 0; internal remainder and counters = 0.
- States: IDLE, MIN, TENS, LOAD.
- IDLE:
  - If seconds != last_seconds: capture seconds into rem (8 b) and last_seconds, clear min_cnt and tens_cnt, go to MIN.
  - Otherwise stay.
- MIN: if rem >= 60, rem <= rem − 60 and min_cnt++, stay; else go to TENS.
- TENS: if rem >= 10, rem <= rem − 10 and tens_cnt++, stay; else go to LOAD.
- LOAD: minutes <= min_cnt, sec_tens <= tens_cnt, sec_ones <= rem[3:0], update <= 1 on the same edge; go to IDLE.
- update is high for exactly the cycle in which the new digits first appear, and 0 otherwise.
- Latency, counted in clock edges from the IDLE edge that captures seconds to the edge that loads the digits: 1 + (m+1) + (t+1) + 1, where m = number of minute subtractions and t = number of tens subtractions.
  - seconds = 0 → 4 edges.
  - seconds = 255 → 9 edges (worst case).
- Input changes mid-conversion are ignored. On return to IDLE the input is compared against last_seconds again, so the final value always converts.
- If seconds is nonzero at reset release, it differs from last_seconds = 0 and converts immediately.
- Width rules: rem is 8 b; subtraction is performed only when rem >= the constant, so no underflow. min_cnt and tens_cnt are 3 b, zero-extended to 4 b on output.
- Reset mid-conversion: abort; all registers return to reset values. Outputs show 0:00.
- Saturated input 255 displays 4:15. No special handling.

Optional Feature:
- Macro: PAUSE_BLINK_EN.
- Enabled:
  - A 23-bit counter runs while pause_song = 1. At BLINK_HALF_PERIOD−1 it wraps to 0 and toggles a phase bit.
  - blank = pause_song & phase.
  - When pause_song = 0, the counter and phase clear to 0 and blank = 0.
  - Blinking therefore starts with a visible half-period.
  - Reset clears the counter, phase and blank.
- Disabled: blank is tied to 0, no counter is instantiated, and pause_song is unused.
- Conversion behaviour is identical in both builds.

Decomposition:
- Shared package: state enum (IDLE/MIN/TENS/LOAD, 2 b); constants SECS_PER_MIN = 60 and TEN = 10; BCD digit width = 4.
- Sub-module `blink_gen` (clk, reset, enable, phase), instantiated only under PAUSE_BLINK_EN.
- Conversion FSM stays in the top module.

Test Plan:
- Reset asserted with seconds = 0 → minutes/sec_tens/sec_ones = 0/0/0, update never pulses, blank = 0.
- seconds 0→75 → digits 1/1/5 exactly 6 edges after capture (m=1, t=1), with a single update pulse.
- seconds 0→255 → digits 4/1/5 after 9 edges; then seconds→59 → digits 0/5/9 after 9 edges (m=0, t=5).
- seconds changes 10→11 during MIN of a conversion of 10 → first update shows 0/1/0, then a second conversion yields 0/1/1.
- Reset asserted in TENS while converting 200 → next cycle outputs 0/0/0, state IDLE, no update; after release with seconds = 200 → 3/2/0.
- With PAUSE_BLINK_EN and BLINK_HALF_PERIOD = 4:
  - pause_song high → blank pattern 0000 1111 0000…
  - pause_song low → blank = 0 the next cycle.
  - Digits remain unchanged throughout.
